// File: rtl/ram_port_arbiter.sv
// Single-cycle arbiter sharing one 2048x32 word RAM between the fetch (I) and data (D) ports.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating conflict resolution; default is fixed D>I priority.
module ram_port_arbiter #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_d_wins;
  logic              w_i_oor;
  logic              w_d_oor;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_rsp_vld;
  logic              r_rsp_own_d;
  logic              r_rsp_oor;
  logic              r_rsp_we;

  assign w_i_oor = (i_addr >= ADDR_W'(MEM_WORDS));
  assign w_d_oor = (d_addr >= ADDR_W'(MEM_WORDS));

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On a conflict D only wins if I took the previous grant
  assign w_d_wins = ~i_req | ~r_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b1;
    end else if (w_gnt_i | w_gnt_d) begin
      r_last_d <= w_gnt_d;
    end
  end
`else
  assign w_d_wins = 1'b1;
`endif

  // Grants are masked while reset is asserted so nothing reaches the RAM
  assign w_gnt_d = rst_n & d_req & w_d_wins;
  assign w_gnt_i = rst_n & i_req & ~w_gnt_d;

  assign i_gnt       = w_gnt_i;
  assign d_gnt       = w_gnt_d;
  assign ram_wren    = w_gnt_d & d_we & ~w_d_oor;
  assign ram_data    = w_gnt_d ? d_wdata : '0;
  assign ram_address = w_gnt_d ? d_addr : (w_gnt_i ? i_addr : r_last_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
    end else if (w_gnt_i | w_gnt_d) begin
      r_last_addr <= ram_address;
    end
  end

  // Response register tracks who owns the RAM output on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_own_d <= 1'b0;
      r_rsp_oor   <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_rsp_vld   <= w_gnt_i | w_gnt_d;
      r_rsp_own_d <= w_gnt_d;
      r_rsp_oor   <= w_gnt_d ? w_d_oor : (w_gnt_i & w_i_oor);
      r_rsp_we    <= w_gnt_d & d_we;
    end
  end

  assign i_rvalid = r_rsp_vld & ~r_rsp_own_d;
  assign d_rvalid = r_rsp_vld & r_rsp_own_d & ~r_rsp_we;
  assign i_err    = i_rvalid & r_rsp_oor;
  assign d_err    = r_rsp_vld & r_rsp_own_d & r_rsp_oor;

  // Out-of-range and idle cycles return zero rather than whatever the RAM is driving
  assign i_rdata = (i_rvalid & ~r_rsp_oor) ? ram_q : '0;
  assign d_rdata = (d_rvalid & ~r_rsp_oor) ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then random traffic against a reference model
// holding its own memory image; a separate RAM image is driven only by the DUT's RAM port.
module tb_ram_port_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MW = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] env_mem [MW];
  logic [DW-1:0] ref_mem [MW];
  bit            ref_last_d;
  bit            last_gi;
  bit            last_gd;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_i_gnt"}, i_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_i_rvalid"}, i_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_i_err"}, i_err, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_ram_wren"}, ram_wren, 0);
  endtask

  // One full clock cycle: entered at a negedge with inputs already driven, leaves at next negedge
  task automatic tick();
    bit            eg_i, eg_d, e_wren, oor;
    bit            nx_iv, nx_ie, nx_dv, nx_de;
    logic [DW-1:0] nx_id, nx_dd;
    bit            s_wren;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    #1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) eg_d = !ref_last_d;
    else eg_d = d_req;
`else
    eg_d = d_req;
`endif
    eg_i = i_req && !eg_d;
    e_wren = eg_d && d_we && (d_addr < AW'(MW));
    chk("i_gnt", i_gnt, eg_i);
    chk("d_gnt", d_gnt, eg_d);
    chk("ram_wren", ram_wren, e_wren);
    if (eg_i || eg_d) chk("ram_address", ram_address, eg_d ? d_addr : i_addr);
    if (e_wren) chk("ram_data", ram_data, d_wdata);
    nx_iv = 0; nx_ie = 0; nx_dv = 0; nx_de = 0; nx_id = '0; nx_dd = '0;
    if (eg_i) begin
      oor   = (i_addr >= AW'(MW));
      nx_iv = 1;
      nx_ie = oor;
      nx_id = oor ? '0 : ref_mem[i_addr];
    end
    if (eg_d) begin
      oor   = (d_addr >= AW'(MW));
      nx_de = oor;
      if (!d_we) begin
        nx_dv = 1;
        nx_dd = oor ? '0 : ref_mem[d_addr];
      end
    end
    s_wren = ram_wren; s_addr = ram_address; s_data = ram_data;
    last_gi = eg_i; last_gd = eg_d;
    @(posedge clk);
    if (s_wren && s_addr < AW'(MW)) env_mem[s_addr] = s_data;
    ram_q = (s_addr < AW'(MW)) ? env_mem[s_addr] : 32'hBAD0_BAD0;
    if (e_wren) ref_mem[d_addr] = d_wdata;
    if (eg_i || eg_d) ref_last_d = eg_d;
    @(negedge clk);
    chk("i_rvalid", i_rvalid, nx_iv);
    chk("i_err", i_err, nx_ie);
    chk("i_rdata", i_rdata, nx_id);
    chk("d_rvalid", d_rvalid, nx_dv);
    chk("d_err", d_err, nx_de);
    chk("d_rdata", d_rdata, nx_dd);
  endtask

  task automatic drv(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                     input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return AW'(MW + $urandom_range(0, 100));
    if (r == 1) return 30'h3FFF_FFFF;
    if (r == 2) return AW'(MW - 1);
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    rst_n = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    ram_q = '0; ref_last_d = 1; last_gi = 0; last_gd = 0;
    for (int k = 0; k < MW; k++) begin
      env_mem[k] = 32'(k) * 32'h9E37_79B9;
      ref_mem[k] = env_mem[k];
    end
    env_mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1;

    // Lone fetch read
    drv(1, 30'h10, 0, 0, '0, '0);
    drv(0, '0, 0, 0, '0, '0);
    // Write then read back the same word
    drv(0, '0, 1, 1, 30'h20, 32'h1234_5678);
    drv(0, '0, 1, 0, 30'h20, '0);
    drv(0, '0, 0, 0, '0, '0);
    // Three-cycle conflict
    drv(1, 30'h10, 1, 0, 30'h20, '0);
    drv(1, 30'h10, 1, 0, 30'h20, '0);
    drv(1, 30'h10, 1, 0, 30'h21, '0);
    drv(0, '0, 0, 0, '0, '0);
    // Out-of-range read and write
    drv(0, '0, 1, 0, 30'h800, '0);
    drv(0, '0, 1, 1, 30'h3FFF_FFFF, 32'hCAFE_F00D);
    drv(0, '0, 0, 0, '0, '0);
    drv(1, 30'h7FF, 0, 0, '0, '0);
    drv(1, 30'h800, 0, 0, '0, '0);
    drv(0, '0, 0, 0, '0, '0);

    // Reset while a fetch response is in flight
    i_req = 1; i_addr = 30'h10;
    #1;
    chk("rst_pre_i_gnt", i_gnt, 1);
    @(posedge clk);
    #1;
    rst_n = 0; i_req = 0;
    #1;
    chk_quiet("rst_inflight");
    @(negedge clk);
    i_req = 1; d_req = 1; d_we = 1; d_addr = 30'h5;
    #1;
    chk_quiet("rst_held");
    repeat (2) @(negedge clk);
    i_req = 0; d_req = 0; d_we = 0;
    rst_n = 1;
    ref_last_d = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_post_i_rvalid", i_rvalid, 0);
    chk("rst_post_d_rvalid", d_rvalid, 0);
    drv(1, 30'h10, 0, 0, '0, '0);
    drv(0, '0, 0, 0, '0, '0);

    // Random traffic; a request is held with its fields until the model says it was granted
    i_req = 0; d_req = 0;
    for (int c = 0; c < 600; c++) begin
      if (!i_req || last_gi) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = rand_addr();
      end
      if (!d_req || last_gd) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) != 0;
        d_addr  = rand_addr();
        d_wdata = $urandom();
      end
      tick();
    end
    drv(0, '0, 0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
